fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//   Front end of the 5-stage pipeline: holds the PC, fetches one 16-bit instruction per cycle,
//   registers it in the IF/ID latch and decodes it. The 3-bit opcode output drives the control
//   unit; the register-field outputs drive the register file.
//   Detects load-use hazards (LDD followed by a dependent instruction), inserts one NOP bubble
//   per hazard and implements HLT.
// PARAMETERS
//   PC_W     10   PC / instruction-memory address width; the PC wraps modulo 2**PC_W
//   INSTR_W  16   instruction width; only 16 is supported
// PORTS
//   clk        in   1        clock; all state updates on the rising edge
//   rst        in   1        synchronous reset, active-high
//   imem_addr  out  PC_W     instruction address; equals the PC register
//   imem_data  in   INSTR_W  instruction at imem_addr, combinational read in the same cycle
//   opcode     out  3        opcode to the control unit; 0 = NOP
//   rd         out  3        destination field
//   rs1        out  3        source-1 field
//   rs2        out  3        source-2 field
//   id_pc      out  PC_W     PC of the instruction in ID
//   stall      out  1        1 while a load-use bubble is being issued this cycle
//   halted     out  1        1 once HLT has issued; cleared only by rst
// BEHAVIOUR
//   Encoding: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
//   Opcodes: 0 NOP; 1 LDD rd=M[rs1]; 2 STD M[rs1]=rs2; 3 ADD rd=rs1+rs2; 4 NOT rd=~rs1;
//     5,6 NOP; 7 HLT.
//   Source use: rs1 by opcodes 1,2,3,4. rs2 by opcodes 2,3 only.
//   Reset: pc=0, IF/ID valid=0, IF/ID instr=0, id_pc=0, ex_load=0, ex_rd=0, halted=0.
//     Consequently opcode/rd/rs1/rs2=0, stall=0 and imem_addr=0 in the cycle after reset.
//   Decode outputs are combinational from the IF/ID latch and the hazard logic.
//   Invalid IF/ID or halted: opcode, rd, rs1 and rs2 all read 0.
//   Latency: the word at imem_addr in cycle N appears on opcode in cycle N+1.
//   hazard = valid & ex_load & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
//     ex_load/ex_rd record the instruction issued in the previous cycle.
//   Normal edge (no hazard, not halted):
//     pc <= pc+1 (wraps)
//     IF/ID <= {imem_data, valid=1}; id_pc <= pc
//     ex_load <= (issued opcode==1); ex_rd <= rd
//   Hazard edge:
//     pc and IF/ID hold; opcode output forced to 0 and stall=1 in that cycle
//     ex_load <= 0, so the bubble clears the hazard; a stall lasts exactly 1 cycle
//   HLT in ID with no hazard:
//     issued as opcode 0
//     edge sets halted=1, IF/ID valid <= 0, pc holds
//     everything stays frozen until rst
//   Opcodes 5 and 6 pass through unchanged on opcode; the control unit treats them as NOP.
//     They never cause a hazard as the producer, because only opcode 1 sets ex_load.
//   rst has priority over every event, including a hazard or HLT in the same cycle.
//     Reset mid-stall discards the held instruction.
// TESTING
//   T1 rst 2 cycles; mem[0]=16'h6530 (ADD r1,r2,r3) -> cycle after 1st fetch edge:
//      opcode=3 rd=1 rs1=2 rs2=3 id_pc=0; imem_addr=1
//   T2 mem[0]=16'h2500 (LDD r1,[r2]), mem[1]=16'h6CC0 (ADD r3,r1,r4) -> opcode seq 1,0,3;
//      stall=1 only in the bubble cycle; imem_addr holds at 2 for that cycle
//   T3 mem[0]=16'h2500, mem[1]=16'h9600 (NOT r5,r4; rs2 field=0, differs from r1)
//      -> seq 1,4, no stall
//   T4 mem[0]=16'h2500, mem[1]=16'h8290 (NOT r0,r5, rs2 field=1)
//      -> no stall (NOT does not read rs2)
//   T5 mem[2]=16'hE000 (HLT) -> halted=1 after its ID cycle; imem_addr frozen at 3;
//      opcode=0 for 20 cycles; then rst -> imem_addr=0, halted=0
//   T6 PC_W=4, all-NOP memory -> imem_addr 15 then 0, id_pc 15 then 0;
//      rst asserted in a T2 bubble cycle -> next cycle opcode=0, stall=0, imem_addr=0

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Pipeline front end: PC, IF/ID latch, field decode, load-use bubble insertion and HLT freeze.
// Decode outputs are combinational from the IF/ID latch; all state is in one clocked block.
module fetch_decode_stage #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [2:0]         opcode,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [PC_W-1:0]    id_pc,
    output logic               stall,
    output logic               halted
);
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDD = 3'd1;
    localparam logic [2:0] OP_STD = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_HLT = 3'd7;

    // Bits [3:0] carry no information, so the latch keeps only [15:4].
    logic [INSTR_W-1:4] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic               vld_q, vld_d;
    logic               ex_load_q, ex_load_d;
    logic [2:0]         ex_rd_q, ex_rd_d;
    logic               halted_q, halted_d;

    logic               unused_lo;
    assign unused_lo = ^imem_data[3:0];

    logic [2:0] f_op, f_rd, f_rs1, f_rs2;
    logic       live, uses_rs1, uses_rs2, hazard, hlt_issue;

    always_comb begin
        f_op     = instr_q[15:13];
        f_rd     = instr_q[12:10];
        f_rs1    = instr_q[9:7];
        f_rs2    = instr_q[6:4];
        live     = vld_q & ~halted_q;
        uses_rs1 = (f_op == OP_LDD) | (f_op == OP_STD) | (f_op == OP_ADD) | (f_op == OP_NOT);
        uses_rs2 = (f_op == OP_STD) | (f_op == OP_ADD);
        hazard   = live & ex_load_q &
                   ((uses_rs1 & (f_rs1 == ex_rd_q)) | (uses_rs2 & (f_rs2 == ex_rd_q)));
        hlt_issue = live & ~hazard & (f_op == OP_HLT);
    end

    // HLT and bubbles both issue as NOP; opcodes 5/6 pass through untouched.
    always_comb begin
        opcode    = (live & ~hazard & (f_op != OP_HLT)) ? f_op : OP_NOP;
        rd        = live ? f_rd  : 3'd0;
        rs1       = live ? f_rs1 : 3'd0;
        rs2       = live ? f_rs2 : 3'd0;
        stall     = hazard;
        halted    = halted_q;
        imem_addr = pc_q;
        id_pc     = id_pc_q;
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        vld_d     = vld_q;
        id_pc_d   = id_pc_q;
        ex_load_d = ex_load_q;
        ex_rd_d   = ex_rd_q;
        halted_d  = halted_q;
        if (halted_q) begin
            // frozen until reset
        end else if (hazard) begin
            ex_load_d = 1'b0;
        end else if (hlt_issue) begin
            halted_d  = 1'b1;
            vld_d     = 1'b0;
            ex_load_d = 1'b0;
        end else begin
            pc_d      = pc_q + 1'b1;
            instr_d   = imem_data[INSTR_W-1:4];
            vld_d     = 1'b1;
            id_pc_d   = pc_q;
            ex_load_d = (opcode == OP_LDD);
            ex_rd_d   = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            instr_q   <= '0;
            vld_q     <= 1'b0;
            id_pc_q   <= '0;
            ex_load_q <= 1'b0;
            ex_rd_q   <= 3'd0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            vld_q     <= vld_d;
            id_pc_q   <= id_pc_d;
            ex_load_q <= ex_load_d;
            ex_rd_q   <= ex_rd_d;
            halted_q  <= halted_d;
        end
    end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a PC_W=10 instance with a program memory
// and a PC_W=4 instance on an all-NOP memory for the wrap case.
module tb_fetch_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic [15:0] mem [0:1023];

    logic [9:0]  imem_addr, id_pc;
    logic [15:0] imem_data;
    logic [2:0]  opcode, rd, rs1, rs2;
    logic        stall, halted;

    logic [3:0]  imem_addr2, id_pc2;
    logic [15:0] imem_data2;
    logic [2:0]  opcode2, rd2, rs12, rs22;
    logic        stall2, halted2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr];
    assign imem_data2 = 16'h0000;

    fetch_decode_stage #(.PC_W(10), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .id_pc(id_pc),
        .stall(stall), .halted(halted)
    );

    fetch_decode_stage #(.PC_W(4), .INSTR_W(16)) dut2 (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .opcode(opcode2), .rd(rd2), .rs1(rs12), .rs2(rs22), .id_pc(id_pc2),
        .stall(stall2), .halted(halted2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_mem();

        // T1: reset state, then single ADD
        mem[0] = 16'h6530;
        do_reset();
        chk("rst_opcode", opcode, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_idpc", id_pc, 0);
        chk("rst_rd", rd, 0);
        tick();
        chk("t1_opcode", opcode, 3);
        chk("t1_rd", rd, 1);
        chk("t1_rs1", rs1, 2);
        chk("t1_rs2", rs2, 3);
        chk("t1_idpc", id_pc, 0);
        chk("t1_addr", imem_addr, 1);

        // T2: LDD r1 then ADD r3,r1,r4 -> one bubble
        clear_mem();
        mem[0] = 16'h2500;
        mem[1] = 16'h6CC0;
        do_reset();
        tick();
        chk("t2_op0", opcode, 1);
        chk("t2_stall0", stall, 0);
        tick();
        chk("t2_op_bub", opcode, 0);
        chk("t2_stall_bub", stall, 1);
        chk("t2_addr_bub", imem_addr, 2);
        tick();
        chk("t2_op2", opcode, 3);
        chk("t2_stall2", stall, 0);
        chk("t2_addr2", imem_addr, 2);
        chk("t2_rs1", rs1, 1);
        tick();
        chk("t2_addr3", imem_addr, 3);

        // T3: NOT r5,r4 after LDD r1 -> no stall
        mem[1] = 16'h9600;
        do_reset();
        tick();
        chk("t3_op0", opcode, 1);
        tick();
        chk("t3_op1", opcode, 4);
        chk("t3_stall", stall, 0);
        chk("t3_rd", rd, 5);

        // T4: NOT r0,r5 with rs2 field = r1 -> no stall
        mem[1] = 16'h8290;
        do_reset();
        tick();
        tick();
        chk("t4_op1", opcode, 4);
        chk("t4_stall", stall, 0);
        chk("t4_rs1", rs1, 5);

        // T5: HLT at address 2
        clear_mem();
        mem[0] = 16'h6530;
        mem[2] = 16'hE000;
        do_reset();
        tick();
        tick();
        tick();
        chk("t5_hlt_op", opcode, 0);
        chk("t5_hlt_not_yet", halted, 0);
        chk("t5_hlt_idpc", id_pc, 2);
        tick();
        chk("t5_halted", halted, 1);
        chk("t5_addr", imem_addr, 3);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_frozen_op", opcode, 0);
        end
        chk("t5_frozen_addr", imem_addr, 3);
        chk("t5_still_halted", halted, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_addr", imem_addr, 0);
        chk("t5_rst_halted", halted, 0);

        // T6a: reset in a bubble cycle discards the held instruction
        clear_mem();
        mem[0] = 16'h2500;
        mem[1] = 16'h6CC0;
        do_reset();
        tick();
        tick();
        chk("t6_bubble", stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_op", opcode, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_addr", imem_addr, 0);

        // T6b: PC_W=4 wrap
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t6_wrap_addr15", imem_addr2, 15);
        chk("t6_wrap_idpc14", id_pc2, 14);
        tick();
        chk("t6_wrap_addr0", imem_addr2, 0);
        chk("t6_wrap_idpc15", id_pc2, 15);
        tick();
        chk("t6_wrap_idpc0", id_pc2, 0);
        chk("t6_wrap_addr1", imem_addr2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
